// File: rtl/data_mem_ls.sv
// data_mem_ls: byte-addressable data memory with byte/half/word loads and
// stores, sign/zero extension, misalignment detection and a hardware zero
// sweep after reset or on request.
//
// Pipeline: edge N accepts a request. A store writes the array at edge N. A
// load or a misaligned/illegal access is captured at edge N. The array is read
// into a register at edge N+1, and Valid rises at that same edge. Dout is
// extracted from the registered read word and the captured lane/size fields.
// It changes only when a load or a misaligned access completes.
module data_mem_ls #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  input  logic        clr,
  output logic        ready,
  output logic        valid,
  output logic [31:0] dout,
  output logic        misalign
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] cnt, cnt_next;

  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  bad, accept, store_en, clearing;
  logic [3:0]            lane_en;
  logic [31:0]           wdata;

  // Request fields captured at the accept edge
  logic                  p_valid, p_we, p_bad, p_uns;
  logic [DEPTH_LOG2-1:0] p_idx;
  logic [1:0]            p_lane, p_size;

  // Fields that shape Dout for the most recent load or misaligned access
  logic                  rd_en;
  logic [31:0]           rd_word;
  logic [1:0]            s_lane, s_size;
  logic                  s_uns, s_zero;

  logic                  unused_bits;
  assign unused_bits = &{1'b0, addr[31:DEPTH_LOG2+2]};

  assign idx      = addr[DEPTH_LOG2+1:2];
  assign lane     = addr[1:0];
  assign ready    = (state == S_IDLE);
  assign clearing = (state == S_CLEAR);
  assign accept   = req & ready & ~clr;
  assign bad      = (size == 2'b11) | ((size == 2'b01) & addr[0]) |
                    ((size == 2'b10) & (addr[1:0] != 2'b00));
  assign store_en = accept & we & ~bad;
  assign rd_en    = p_valid & (~p_we | p_bad);

  // State register and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: the sweep ends on the edge that zeroes the last index; Clr restarts it
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_CLEAR: begin
        if (clr) begin
          cnt_next = '0;
        end else if (cnt == {DEPTH_LOG2{1'b1}}) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + DEPTH_LOG2'(1);
        end
      end
      default: begin
        if (clr) begin
          cnt_next   = '0;
          state_next = S_CLEAR;
        end
      end
    endcase
  end

  // Per-lane write enables and right-aligned store data replicated onto lanes
  always_comb begin
    lane_en = 4'b0000;
    wdata   = din;
    case (size)
      2'b00: begin
        lane_en[lane] = 1'b1;
        wdata         = {4{din[7:0]}};
      end
      2'b01: begin
        lane_en = addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{din[15:0]}};
      end
      default: lane_en = 4'b1111;
    endcase
  end

  // One byte-wide array per lane, each with its own write enable and registered read
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      // Sweep write, lane store, and registered read (old data on same-edge write)
      always_ff @(posedge clk) begin
        if (clearing) begin
          mem[cnt] <= 8'h00;
        end else if (store_en && lane_en[gi]) begin
          mem[idx] <= wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rd_q <= mem[p_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Capture accepted requests; Clr or a not-ready cycle yields no capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_we    <= 1'b0;
      p_bad   <= 1'b0;
      p_uns   <= 1'b0;
      p_idx   <= '0;
      p_lane  <= 2'b00;
      p_size  <= 2'b00;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_we   <= we;
        p_bad  <= bad;
        p_uns  <= unsigned_load;
        p_idx  <= idx;
        p_lane <= lane;
        p_size <= size;
      end
    end
  end

  // Acknowledge pulse and the fields that shape Dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      misalign <= 1'b0;
      s_lane   <= 2'b00;
      s_size   <= 2'b10;
      s_uns    <= 1'b0;
      s_zero   <= 1'b1;
    end else begin
      valid    <= p_valid;
      misalign <= p_valid & p_bad;
      if (rd_en) begin
        s_lane <= p_lane;
        s_size <= p_size;
        s_uns  <= p_uns;
        s_zero <= p_bad;
      end
    end
  end

  // Load extraction and extension; misaligned accesses and reset force zero
  logic [31:0] shifted;
  logic [15:0] half;
  assign shifted = rd_word >> {s_lane, 3'b000};
  assign half    = s_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    dout = rd_word;
    case (s_size)
      2'b00:   dout = {{24{shifted[7] & ~s_uns}}, shifted[7:0]};
      2'b01:   dout = {{16{half[15] & ~s_uns}}, half};
      default: dout = rd_word;
    endcase
    if (s_zero) begin
      dout = 32'h0;
    end
  end

endmodule

// File: tb/tb_data_mem_ls.sv
// Directed testbench for data_mem_ls at DEPTH_LOG2=5.
module tb_data_mem_ls;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, unsigned_load, clr;
  logic [31:0] addr, din;
  logic [1:0]  size;
  logic        ready, valid, misalign;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  data_mem_ls #(.DEPTH_LOG2(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .din(din),
    .size(size), .unsigned_load(unsigned_load), .clr(clr),
    .ready(ready), .valid(valid), .dout(dout), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req = 1'b0; we = 1'b0; addr = 32'h0; din = 32'h0;
    size = 2'b10; unsigned_load = 1'b0; clr = 1'b0;
  endtask

  // One isolated access; reports Valid after the accept edge and the outputs after the next edge
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic u,
                        output logic v0, output logic v1, output logic mis,
                        output logic [31:0] dq);
    req = 1'b1; we = w; addr = a; din = d; size = s; unsigned_load = u;
    step();
    v0 = valid;
    idle_in();
    step();
    v1  = valid;
    mis = misalign;
    dq  = dout;
  endtask

  // Counts post-edge samples with Ready=0, starting from the current one
  task automatic count_sweep(output int n, output int valid_seen);
    n = 0;
    valid_seen = 0;
    while (!ready && n < 200) begin
      if (valid) valid_seen++;
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    logic v0, v1, mis;
    logic [31:0] dq;
    int n, vs;
    idle_in();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (ready !== 1'b0 || valid !== 1'b0 || misalign !== 1'b0 || dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b misalign=%b dout=%h, required 0 0 0 00000000",
               ready, valid, misalign, dout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_sweep(n, vs);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL reset_sweep_len: ready low for %0d cycles, required 32", n);
    end
    $display("reset: sweep %0d cycles", n);
    access(1'b0, 32'h00, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b1 || mis !== 1'b0 || dq !== 32'h0) begin
      errors++;
      $display("FAIL lw_idx0: v0=%b v1=%b mis=%b dout=%h, required 0 1 0 00000000", v0, v1, mis, dq);
    end
    access(1'b0, 32'h44, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (v1 !== 1'b1 || dq !== 32'h0) begin
      errors++;
      $display("FAIL lw_idx17: valid=%b dout=%h, required 1 00000000", v1, dq);
    end
    access(1'b0, 32'h7C, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (v1 !== 1'b1 || dq !== 32'h0) begin
      errors++;
      $display("FAIL lw_idx31: valid=%b dout=%h, required 1 00000000", v1, dq);
    end
    $display("reset: word loads idx 0/17/31 done");
  endtask

  task automatic test_extend();
    logic v0, v1, mis;
    logic [31:0] dq;
    access(1'b1, 32'h10, 32'h8899AABC, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (v1 !== 1'b1 || mis !== 1'b0) begin
      errors++;
      $display("FAIL sw_ack: valid=%b misalign=%b, required 1 0", v1, mis);
    end
    access(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'hFFFFFF88 || v1 !== 1'b1) begin
      errors++;
      $display("FAIL lb_13: dout=%h valid=%b, required ffffff88 1", dq, v1);
    end
    $display("lb  @13 -> %h", dq);
    access(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h00000088) begin
      errors++;
      $display("FAIL lbu_13: dout=%h, required 00000088", dq);
    end
    $display("lbu @13 -> %h", dq);
    access(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'hFFFFAABC) begin
      errors++;
      $display("FAIL lh_10: dout=%h, required ffffaabc", dq);
    end
    $display("lh  @10 -> %h", dq);
    access(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h00008899 || mis !== 1'b0) begin
      errors++;
      $display("FAIL lhu_12: dout=%h misalign=%b, required 00008899 0", dq, mis);
    end
    $display("lhu @12 -> %h", dq);
  endtask

  task automatic test_back_to_back();
    req = 1'b1; we = 1'b1; addr = 32'h11; din = 32'h0000005A; size = 2'b00; unsigned_load = 1'b0;
    step();
    we = 1'b0; addr = 32'h10; din = 32'h0; size = 2'b10;
    step();
    checks++;
    if (valid !== 1'b1 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sb_ack: valid=%b misalign=%b, required 1 0", valid, misalign);
    end
    idle_in();
    step();
    checks++;
    if (valid !== 1'b1 || dout !== 32'h88995ABC) begin
      errors++;
      $display("FAIL b2b_lw: valid=%b dout=%h, required 1 88995abc", valid, dout);
    end
    $display("b2b sb/lw @10 -> %h", dout);
    step();
    checks++;
    if (valid !== 1'b0 || dout !== 32'h88995ABC) begin
      errors++;
      $display("FAIL b2b_pulse_hold: valid=%b dout=%h, required 0 88995abc", valid, dout);
    end
  endtask

  task automatic test_misalign();
    logic v0, v1, mis;
    logic [31:0] dq;
    access(1'b1, 32'h04, 32'h11223344, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h88995ABC) begin
      errors++;
      $display("FAIL store_hold_dout: dout=%h, required 88995abc", dq);
    end
    access(1'b0, 32'h06, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (v1 !== 1'b1 || mis !== 1'b1 || dq !== 32'h0) begin
      errors++;
      $display("FAIL lw_06: valid=%b misalign=%b dout=%h, required 1 1 00000000", v1, mis, dq);
    end
    $display("lw @06 misalign=%b dout=%h", mis, dq);
    access(1'b0, 32'h04, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    access(1'b1, 32'h03, 32'h1234, 2'b01, 1'b0, v0, v1, mis, dq);
    checks++;
    if (v1 !== 1'b1 || mis !== 1'b1 || dq !== 32'h0) begin
      errors++;
      $display("FAIL sh_03: valid=%b misalign=%b dout=%h, required 1 1 00000000", v1, mis, dq);
    end
    $display("sh @03 misalign=%b dout=%h", mis, dq);
    access(1'b1, 32'h00, 32'hFFFFFFFF, 2'b11, 1'b0, v0, v1, mis, dq);
    checks++;
    if (v1 !== 1'b1 || mis !== 1'b1 || dq !== 32'h0) begin
      errors++;
      $display("FAIL size11_00: valid=%b misalign=%b dout=%h, required 1 1 00000000", v1, mis, dq);
    end
    access(1'b0, 32'h04, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h11223344 || mis !== 1'b0) begin
      errors++;
      $display("FAIL word04_intact: dout=%h misalign=%b, required 11223344 0", dq, mis);
    end
    access(1'b0, 32'h00, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h0) begin
      errors++;
      $display("FAIL word00_intact: dout=%h, required 00000000", dq);
    end
    $display("misalign: word 04 = 11223344 expected, word 00 = 0 expected");
  endtask

  task automatic test_alias();
    logic v0, v1, mis;
    logic [31:0] dq;
    access(1'b1, 32'h84, 32'hDEADBEEF, 2'b10, 1'b0, v0, v1, mis, dq);
    access(1'b0, 32'h04, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'hDEADBEEF || mis !== 1'b0) begin
      errors++;
      $display("FAIL alias_84: dout=%h, required deadbeef", dq);
    end
    $display("alias sw @84 / lw @04 -> %h", dq);
  endtask

  task automatic test_clear();
    logic v0, v1, mis;
    logic [31:0] dq;
    int n, vs;
    req = 1'b1; we = 1'b0; addr = 32'h04; size = 2'b10; clr = 1'b1;
    step();
    clr = 1'b0;
    // Keep requesting a load through the sweep; none may be acknowledged
    count_sweep(n, vs);
    idle_in();
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL clr_sweep_len: ready low for %0d cycles, required 32", n);
    end
    checks++;
    if (vs !== 0) begin
      errors++;
      $display("FAIL clr_no_valid: %0d valid cycles during sweep, required 0", vs);
    end
    $display("clr: sweep %0d cycles, %0d valids", n, vs);
    access(1'b0, 32'h04, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h0 || v1 !== 1'b1) begin
      errors++;
      $display("FAIL clr_word04: dout=%h valid=%b, required 00000000 1", dq, v1);
    end
    access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h0) begin
      errors++;
      $display("FAIL clr_word10: dout=%h, required 00000000", dq);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic v0, v1, mis;
    logic [31:0] dq;
    int n, vs;
    access(1'b1, 32'h08, 32'hCAFE0001, 2'b10, 1'b0, v0, v1, mis, dq);
    access(1'b0, 32'h08, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL pre_rst_load: dout=%h, required cafe0001", dq);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || valid !== 1'b0 || dout !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_outputs: ready=%b valid=%b dout=%h, required 0 0 00000000",
               ready, valid, dout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_sweep(n, vs);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL mid_rst_sweep_len: ready low for %0d cycles, required 32", n);
    end
    $display("mid-sweep reset: sweep %0d cycles", n);
    access(1'b0, 32'h08, 32'h0, 2'b10, 1'b0, v0, v1, mis, dq);
    checks++;
    if (dq !== 32'h0 || v1 !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_word08: dout=%h valid=%b, required 00000000 1", dq, v1);
    end
  endtask

  initial begin
    test_reset();
    test_extend();
    test_back_to_back();
    test_misalign();
    test_alias();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
